// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_arbiter_if : CPU, display and RAM command/return bundle for ram_arbiter
// Revision: 1.0
// ============================================================================
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  cpu_avl_ready;
  logic [ADDR_WIDTH-1:0] cpu_avl_addr;
  logic [63:0]           cpu_avl_wdata;
  logic [7:0]            cpu_avl_be;
  logic                  cpu_avl_read_req;
  logic                  cpu_avl_write_req;
  logic [63:0]           cpu_avl_rdata;
  logic                  cpu_avl_rdata_valid;

  logic                  display_avl_ready;
  logic [ADDR_WIDTH-1:0] display_avl_addr;
  logic [7:0]            display_avl_be;
  logic                  display_avl_read_req;
  logic [63:0]           display_avl_rdata;
  logic                  display_avl_rdata_valid;

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [7:0]            ram_byteena;
  logic [63:0]           ram_data;
  logic                  ram_wren;
  logic [63:0]           ram_q;

  // Arbiter side: consumes requests and RAM read data, drives everything else.
  modport slave (
    output cpu_avl_ready, cpu_avl_rdata, cpu_avl_rdata_valid,
    input  cpu_avl_addr, cpu_avl_wdata, cpu_avl_be, cpu_avl_read_req, cpu_avl_write_req,
    output display_avl_ready, display_avl_rdata, display_avl_rdata_valid,
    input  display_avl_addr, display_avl_be, display_avl_read_req,
    output ram_address, ram_byteena, ram_data, ram_wren,
    input  ram_q
  );

  // Environment side: requesters plus the RAM itself.
  modport master (
    input  cpu_avl_ready, cpu_avl_rdata, cpu_avl_rdata_valid,
    output cpu_avl_addr, cpu_avl_wdata, cpu_avl_be, cpu_avl_read_req, cpu_avl_write_req,
    input  display_avl_ready, display_avl_rdata, display_avl_rdata_valid,
    output display_avl_addr, display_avl_be, display_avl_read_req,
    input  ram_address, ram_byteena, ram_data, ram_wren,
    output ram_q
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// ram_arbiter : display-priority arbiter for a shared single-port 64-bit RAM
// Revision: 1.0
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_WIDTH        = 14,
  parameter int READ_LATENCY      = 1,
  parameter int MAX_DISPLAY_BURST = 8
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);
  localparam logic [7:0] BURST_LIMIT = 8'(MAX_DISPLAY_BURST);

  logic                  cpu_req;
  logic                  force_cpu;
  logic                  display_ready;
  logic                  cpu_ready;
  logic                  display_accept;
  logic                  cpu_accept;
  logic                  cpu_write_accept;
  logic                  read_accept;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [7:0]            win_be;

  logic [ADDR_WIDTH-1:0] address_q;
  logic [7:0]            byteena_q;
  logic [63:0]           data_q;
  logic                  wren_q;
  logic [7:0]            starve_cnt;
  logic [READ_LATENCY:0] tag_valid;
  logic [READ_LATENCY:0] tag_display;

  // The two readys are mutually exclusive whenever both sides request,
  // so at most one acceptance can occur per cycle.
  always_comb begin
    cpu_req          = bus.cpu_avl_read_req | bus.cpu_avl_write_req;
    force_cpu        = (starve_cnt == BURST_LIMIT);
    display_ready    = !(force_cpu & cpu_req);
    cpu_ready        = !bus.display_avl_read_req | force_cpu;
    display_accept   = bus.display_avl_read_req & display_ready;
    cpu_accept       = cpu_req & cpu_ready;
    // Simultaneous CPU read+write is treated as a write only.
    cpu_write_accept = cpu_accept & bus.cpu_avl_write_req;
    read_accept      = display_accept | (cpu_accept & !bus.cpu_avl_write_req);
    win_addr         = display_accept ? bus.display_avl_addr : bus.cpu_avl_addr;
    win_be           = display_accept ? bus.display_avl_be   : bus.cpu_avl_be;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      address_q   <= '0;
      byteena_q   <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      starve_cnt  <= '0;
      tag_valid   <= '0;
      tag_display <= '0;
    end else begin
      wren_q <= cpu_write_accept;
      if (display_accept | cpu_accept) begin
        address_q <= win_addr;
        byteena_q <= win_be;
      end
      if (cpu_write_accept) begin
        data_q <= bus.cpu_avl_wdata;
      end

      if (!cpu_req || cpu_accept) begin
        starve_cnt <= '0;
      end else if (display_accept && (starve_cnt != BURST_LIMIT)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      // Stage k is visible k+1 cycles after acceptance; the last stage lines
      // up with ram_q for the address registered in the acceptance cycle.
      tag_valid   <= {tag_valid[READ_LATENCY-1:0], read_accept};
      tag_display <= {tag_display[READ_LATENCY-1:0], display_accept};
    end
  end

  assign bus.cpu_avl_ready           = cpu_ready;
  assign bus.display_avl_ready       = display_ready;
  assign bus.ram_address             = address_q;
  assign bus.ram_byteena             = byteena_q;
  assign bus.ram_data                = data_q;
  assign bus.ram_wren                = wren_q;
  assign bus.cpu_avl_rdata           = bus.ram_q;
  assign bus.display_avl_rdata       = bus.ram_q;
  assign bus.cpu_avl_rdata_valid     = tag_valid[READ_LATENCY] & !tag_display[READ_LATENCY];
  assign bus.display_avl_rdata_valid = tag_valid[READ_LATENCY] &  tag_display[READ_LATENCY];
endmodule
`default_nettype wire
